vector_cmd_queue: RTL and testbench
===================================

Name: vector_cmd_queue

Overview:
- Command front end for the `draw` line engine.
- Accepts a stream of 16-bit vector words (MOVE/DRAW in two-word form) from the host/instrument bus and tracks the current pen position.
- Queues completed line segments in a FIFO and presents them to `draw` over a valid/ready handshake. Replaces the free-running test coordinate generator.
- Runs in the `cnt == 1 && init_done` slot via `enable`.

Parameters:
- DEPTH, 16, FIFO entries; power of two.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk50  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- enable  input  1  time-slot qualifier; all state advances only when high
- in_word  input  16  vector command word
- in_valid  input  1  in_word valid
- in_ready  output  1  word accepted on clk50 edge when in_valid && in_ready && enable
- x_from  output  9  segment start X
- y_from  output  8  segment start Y
- x_to  output  9  segment end X
- y_to  output  8  segment end Y
- out_valid  output  1  segment on x_from..y_to valid
- draw_ready  input  1  draw engine idle, can take a segment
- level  output  ADDR_W+1  entries in FIFO, not counting the output register
- err_count  output  8  saturating count of protocol errors

Behaviour:
- Word format:
  - Header word: [15]=1, [14]=op (1=DRAW, 0=MOVE), [13:9] ignored, [8:0]=X.
  - Data word: [15]=0, [14:8] ignored, [7:0]=Y.
- Parser FSM, states WAIT_X and WAIT_Y:
  - WAIT_X + header: latch X and op, go to WAIT_Y.
  - WAIT_X + data word: discard it, err_count+1, stay in WAIT_X.
  - WAIT_Y + data word with op=MOVE: cur_x/cur_y <= X/Y, no push, go to WAIT_X.
  - WAIT_Y + data word with op=DRAW: push {cur_x, cur_y, X, Y}, cur <= X/Y, go to WAIT_X.
  - WAIT_Y + header: err_count+1, re-latch X/op from the new header, stay in WAIT_Y. The previous half-command is dropped.
- in_ready = enable && !full. It gates every word, headers included. full means level == DEPTH.
- FIFO:
  - 34-bit entries, circular wr/rd pointers of ADDR_W bits, wrap modulo DEPTH.
  - Push and pop in the same cycle leave level unchanged.
  - No push when full; in_ready already prevents it.
- Output stage: registered, first-word-fall-through.
  - When out_valid==0 or a handshake (out_valid && draw_ready && enable) occurs, load the next FIFO entry if level>0 and set out_valid=1. Otherwise clear out_valid.
  - Back-to-back segments are supported: one segment per enabled cycle.
  - x_from..y_to hold stable while out_valid && !draw_ready. They also hold their last value when out_valid==0.
- Latency: data word accepted at edge N with FIFO and output empty -> FIFO write at N, out_valid=1 after edge N+1 (enabled edges).
- enable low: no word accepted, no push, no pop, no FSM transition. Outputs hold.
- err_count saturates at 255.
- Coordinates are passed unclipped at full 9/8-bit width.
- Reset (async, rst high):
  - FSM to WAIT_X; cur_x=0, cur_y=0.
  - Pointers, level, err_count = 0.
  - out_valid=0; x_from, y_from, x_to, y_to = 0.
  - in_ready=0 while rst high.
  - Reset mid-command drops the pending header and all queued segments.

Test Plan:
- After reset, MOVE(10,20) then DRAW(100,50) with draw_ready=1, enable=1 -> exactly one segment (10,20)->(100,50); out_valid high for 1 cycle, 2 edges after the Y word; err_count=0.
- DRAW(5,5), DRAW(300,255), DRAW(511,0) back-to-back with draw_ready=0 -> level=2 and output reg holds (0,0)->(5,5). Raise draw_ready -> (5,5)->(300,255) then (300,255)->(511,0) on consecutive cycles.
- 17 DRAW commands with draw_ready=0, DEPTH=16 -> in_ready drops once level=16. A pop frees one slot and the next word is accepted; pointer wrap preserves order across 40 total segments.
- Data word in WAIT_X, then header DRAW X=7 followed by header MOVE X=9 and data Y=3 -> err_count=2, no segment, cur=(9,3).
- Toggle enable every cycle during a 3-segment burst -> identical segment sequence; no accept or pop on enable-low edges.
- Assert rst while in WAIT_Y with 4 queued -> out_valid=0, level=0, err_count=0 immediately. Next DRAW(1,1) yields (0,0)->(1,1).

Source files
------------

// File: rtl/vector_cmd_queue.sv
// ============================================================================
// Module   : vector_cmd_queue
// Brief    : Parses MOVE/DRAW vector words, tracks the pen and queues line
//            segments for the draw engine behind a FWFT output register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vector_cmd_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [8:0]        x_from,
  output logic [7:0]        y_from,
  output logic [8:0]        x_to,
  output logic [7:0]        y_to,
  output logic              out_valid,
  input  logic              draw_ready,
  output logic [ADDR_W:0]   level,
  output logic [7:0]        err_count
);

  typedef enum logic [0:0] {
    WAIT_X = 1'b0,
    WAIT_Y = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [8:0]          r_hdr_x;
  logic                r_hdr_op;
  logic [8:0]          r_cur_x;
  logic [7:0]          r_cur_y;
  logic [33:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_level;
  logic [33:0]         r_seg;
  logic                r_out_valid;
  logic [7:0]          r_err;

  logic                w_full;
  logic                w_accept;
  logic                w_is_hdr;
  logic                w_latch_hdr;
  logic                w_pen_upd;
  logic                w_push;
  logic                w_err;
  logic                w_load;
  logic                w_pop;
  logic [33:0]         w_entry;
  logic                w_unused;

  assign w_full   = (r_level == c_DEPTH);
  // rst term keeps the bus stalled for the whole reset pulse
  assign in_ready = enable && !w_full && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_is_hdr = in_word[15];
  assign w_entry  = {r_cur_x, r_cur_y, r_hdr_x, in_word[7:0]};
  assign w_unused = ^in_word[13:9];

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) r_state <= WAIT_X;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_hdr = 1'b0;
    w_pen_upd   = 1'b0;
    w_push      = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      case (r_state)
        WAIT_X: begin
          if (w_is_hdr) begin
            w_latch_hdr = 1'b1;
            w_state_nxt = WAIT_Y;
          end else begin
            w_err = 1'b1;
          end
        end
        WAIT_Y: begin
          if (w_is_hdr) begin
            // a new header abandons the half-built command
            w_latch_hdr = 1'b1;
            w_err       = 1'b1;
          end else begin
            w_pen_upd   = 1'b1;
            w_push      = r_hdr_op;
            w_state_nxt = WAIT_X;
          end
        end
        default: w_state_nxt = WAIT_X;
      endcase
    end
  end

  assign w_load = enable && (!r_out_valid || draw_ready);
  assign w_pop  = w_load && (r_level != '0);

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_hdr_x     <= '0;
      r_hdr_op    <= 1'b0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_seg       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      if (w_latch_hdr) begin
        r_hdr_x  <= in_word[8:0];
        r_hdr_op <= in_word[14];
      end
      if (w_pen_upd) begin
        r_cur_x <= r_hdr_x;
        r_cur_y <= in_word[7:0];
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (w_load) begin
        if (r_level != '0) begin
          r_seg       <= r_mem[r_rd_ptr];
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_err && (r_err != 8'hFF)) r_err <= r_err + 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign {x_from, y_from, x_to, y_to} = r_seg;
  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vector_cmd_queue.sv
// ============================================================================
// Module   : tb_vector_cmd_queue
// Brief    : Directed and random stimulus for vector_cmd_queue against a
//            queue-based behavioural model of the command stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vector_cmd_queue;

  localparam int DEPTH = 16;

  logic        clk50 = 1'b0;
  logic        rst   = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  x_from;
  logic [7:0]  y_from;
  logic [8:0]  x_to;
  logic [7:0]  y_to;
  logic        out_valid;
  logic        draw_ready = 1'b0;
  logic [4:0]  level;
  logic [7:0]  err_count;

  vector_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk50(clk50), .rst(rst), .enable(enable), .in_word(in_word),
    .in_valid(in_valid), .in_ready(in_ready), .x_from(x_from),
    .y_from(y_from), .x_to(x_to), .y_to(y_to), .out_valid(out_valid),
    .draw_ready(draw_ready), .level(level), .err_count(err_count)
  );

  always #5 clk50 = ~clk50;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // behavioural model: segment queue plus one presented slot
  logic [33:0] m_q[$];
  bit          m_outv;
  logic [33:0] m_out;
  bit          m_pend, m_op, m_acc;
  logic [8:0]  m_hx, m_cx;
  logic [7:0]  m_cy;
  int          m_err;
  logic [33:0] dut_hs[$];

  function automatic logic [33:0] seg(input int x0, input int y0, input int x1, input int y1);
    return {9'(x0), 8'(y0), 9'(x1), 8'(y1)};
  endfunction

  function automatic logic [15:0] hdr(input bit op, input int x);
    return {1'b1, op, 5'b0, 9'(x)};
  endfunction

  function automatic logic [15:0] dat(input int y);
    return {8'h00, 8'(y)};
  endfunction

  function automatic logic [33:0] hs_at(input int i);
    if (i < dut_hs.size()) return dut_hs[i];
    return 'x;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_outv = 0; m_out = '0; m_pend = 0; m_op = 0; m_acc = 0;
    m_hx = '0; m_cx = '0; m_cy = '0; m_err = 0;
  endtask

  task automatic model_edge();
    bit rdy;
    m_acc = 0;
    if (enable) begin
      rdy = (m_q.size() < DEPTH);
      if (!m_outv || draw_ready) begin
        if (m_q.size() > 0) begin m_out = m_q.pop_front(); m_outv = 1; end
        else m_outv = 0;
      end
      if (in_valid && rdy) begin
        m_acc = 1;
        if (in_word[15]) begin
          if (m_pend) m_err = (m_err < 255) ? m_err + 1 : 255;
          m_pend = 1; m_op = in_word[14]; m_hx = in_word[8:0];
        end else if (!m_pend) begin
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end else begin
          if (m_op) m_q.push_back({m_cx, m_cy, m_hx, in_word[7:0]});
          m_cx = m_hx; m_cy = in_word[7:0]; m_pend = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", in_ready, (enable && m_q.size() < DEPTH));
    chk("out_valid", out_valid, m_outv);
    chk("segment", {x_from, y_from, x_to, y_to}, m_out);
    chk("level", level, m_q.size());
    chk("err_count", err_count, m_err);
  endtask

  task automatic cyc();
    if (out_valid && draw_ready && enable) dut_hs.push_back({x_from, y_from, x_to, y_to});
    @(posedge clk50);
    model_edge();
    @(negedge clk50);
    compare_all();
  endtask

  task automatic word(input logic [15:0] w);
    in_valid = 1'b1;
    in_word  = w;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (m_acc) break;
    end
    if (!m_acc) chk("word_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_err", err_count, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk50);
    rst = 1'b0;
    dut_hs.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] wl[$];
    logic [33:0] exp_seg[$];
    int          px, py, nx, ny, idx;
    bit          saw_full;

    @(negedge clk50);
    enable = 1'b1;
    do_reset();
    chk("reset_segment", {x_from, y_from, x_to, y_to}, 34'h0);

    // MOVE then DRAW with the engine always ready
    draw_ready = 1'b1;
    word(hdr(0, 10)); word(dat(20)); word(hdr(1, 100)); word(dat(50));
    repeat (4) cyc();
    chk("t1_count", dut_hs.size(), 1);
    chk("t1_seg", hs_at(0), seg(10, 20, 100, 50));
    chk("t1_err", err_count, 0);

    // three DRAWs against a stalled engine
    do_reset();
    draw_ready = 1'b0;
    word(hdr(1, 5));   word(dat(5));
    word(hdr(1, 300)); word(dat(255));
    word(hdr(1, 511)); word(dat(0));
    repeat (2) cyc();
    chk("t2_level", level, 2);
    chk("t2_hold", {x_from, y_from, x_to, y_to}, seg(0, 0, 5, 5));
    draw_ready = 1'b1;
    repeat (4) cyc();
    chk("t2_count", dut_hs.size(), 3);
    chk("t2_seg1", hs_at(1), seg(5, 5, 300, 255));
    chk("t2_seg2", hs_at(2), seg(300, 255, 511, 0));

    // fill to full, then drain across pointer wrap
    do_reset();
    draw_ready = 1'b0;
    px = 0; py = 0;
    for (int k = 0; k < 40; k++) begin
      nx = $urandom_range(0, 511); ny = $urandom_range(0, 255);
      wl.push_back(hdr(1, nx)); wl.push_back(dat(ny));
      exp_seg.push_back(seg(px, py, nx, ny));
      px = nx; py = ny;
    end
    idx = 0; saw_full = 0;
    for (int c = 0; c < 600 && (idx < wl.size() || dut_hs.size() < 40); c++) begin
      draw_ready = (c >= 60) ? ($urandom_range(0, 2) != 0) : 1'b0;
      in_valid   = (idx < wl.size());
      in_word    = (idx < wl.size()) ? wl[idx] : 16'h0;
      if (level == 5'd16 && !in_ready) saw_full = 1;
      cyc();
      if (m_acc) idx++;
    end
    in_valid = 1'b0;
    chk("t3_full_seen", saw_full, 1);
    chk("t3_count", dut_hs.size(), 40);
    for (int k = 0; k < 40; k++) chk("t3_order", hs_at(k), exp_seg[k]);

    // protocol errors
    do_reset();
    draw_ready = 1'b1;
    word(dat(17)); word(hdr(1, 7)); word(hdr(0, 9)); word(dat(3));
    repeat (3) cyc();
    chk("t4_err", err_count, 2);
    chk("t4_nosegment", dut_hs.size(), 0);
    word(hdr(1, 0)); word(dat(0));
    repeat (3) cyc();
    chk("t4_pen", hs_at(0), seg(9, 3, 0, 0));

    // enable toggling every cycle during a burst
    do_reset();
    draw_ready = 1'b1;
    wl.delete();
    wl = '{hdr(1, 11), dat(12), hdr(1, 13), dat(14), hdr(1, 15), dat(16)};
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      enable   = c[0];
      in_valid = (idx < wl.size());
      in_word  = (idx < wl.size()) ? wl[idx] : 16'h0;
      cyc();
      if (m_acc) idx++;
    end
    enable = 1'b1; in_valid = 1'b0;
    chk("t5_count", dut_hs.size(), 3);
    chk("t5_seg0", hs_at(0), seg(0, 0, 11, 12));
    chk("t5_seg2", hs_at(2), seg(13, 14, 15, 16));

    // reset while a header is pending and segments are queued
    do_reset();
    draw_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin word(hdr(1, k)); word(dat(k)); end
    word(hdr(1, 200));
    chk("t6_level_pre", level, 4);
    #2;
    do_reset();
    draw_ready = 1'b1;
    word(hdr(1, 1)); word(dat(1));
    repeat (3) cyc();
    chk("t6_seg", hs_at(0), seg(0, 0, 1, 1));

    // error counter saturation
    do_reset();
    in_valid = 1'b1; in_word = dat(0);
    repeat (260) cyc();
    in_valid = 1'b0;
    chk("t7_saturate", err_count, 255);

    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      enable     = ($urandom_range(0, 3) != 0);
      draw_ready = (c % 400 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      in_valid   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1)) in_word = hdr($urandom_range(0, 3) != 0, $urandom_range(0, 511));
      else                      in_word = {1'b0, 7'($urandom), 8'($urandom)};
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
